// File: rtl/mat_operand_sequencer.sv
// mat_operand_sequencer: walks C = A x B over two operand RAMs. It streams
// element pairs into the `mat` multiplier, accumulates the returned products
// and writes each finished dot product to the result RAM port.
// Optional build macro: MAT_SEQ_SAT_ACC_EN selects a saturating accumulator.
// When the macro is not defined, the accumulator wraps modulo 2**DATA_W.
module mat_operand_sequencer #(
  parameter int DATA_W  = 32,
  parameter int DIM     = 4,
  parameter int ADDR_W  = 4,
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  logic [DATA_W-1:0] a_rd_data,
  input  logic [DATA_W-1:0] b_rd_data,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic [DATA_W-1:0] mul_c,
  output logic              c_wr_en,
  output logic [ADDR_W-1:0] c_wr_addr,
  output logic [DATA_W-1:0] c_wr_data
);

  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CW = $clog2(DIM + 1);
  localparam int VD = 2 + MUL_LAT;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIM - 1);
  localparam logic [CW-1:0] RCV_LAST = CW'(DIM - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     i_q, j_q, k_q;
  logic [CW-1:0]     rcv_q;
  logic [DATA_W-1:0] acc_q, acc_nx;
  logic [VD-1:0]     vld_q;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q;
  logic [ADDR_W-1:0] a_addr_cur, b_addr_cur, c_addr_cur;
  logic              issue, take, last_elem;

  assign issue      = (state == ISSUE);
  assign take       = vld_q[VD-1];
  assign last_elem  = (i_q == IDX_LAST) && (j_q == IDX_LAST);
  assign a_addr_cur = ADDR_W'(i_q) * ADDR_W'(DIM) + ADDR_W'(k_q);
  assign b_addr_cur = ADDR_W'(k_q) * ADDR_W'(DIM) + ADDR_W'(j_q);
  assign c_addr_cur = ADDR_W'(i_q) * ADDR_W'(DIM) + ADDR_W'(j_q);

`ifdef MAT_SEQ_SAT_ACC_EN
  logic [DATA_W:0] acc_sum;
  assign acc_sum = {1'b0, acc_q} + {1'b0, mul_c};
  // A carry out clamps to all-ones; once clamped, any further add carries again.
  assign acc_nx  = acc_sum[DATA_W] ? '1 : acc_sum[DATA_W-1:0];
`else
  assign acc_nx  = acc_q + mul_c;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // nothing but clk appears in the sensitivity list.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and the state-derived outputs.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    state_nx  = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    a_rd_addr = a_addr_q;
    b_rd_addr = b_addr_q;
    c_wr_en   = 1'b0;
    c_wr_addr = '0;
    c_wr_data = '0;
    unique case (state)
      IDLE:  if (start) state_nx = ISSUE;
      ISSUE: begin
        a_rd_addr = a_addr_cur;
        b_rd_addr = b_addr_cur;
        if (k_q == IDX_LAST) state_nx = DRAIN;
      end
      // The last product lands at the end of this cycle, so WRITE follows
      // directly and sees the finished sum.
      DRAIN: if (take && (rcv_q == RCV_LAST)) state_nx = WRITE;
      WRITE: begin
        c_wr_en   = 1'b1;
        c_wr_addr = c_addr_cur;
        c_wr_data = acc_q;
        state_nx  = last_elem ? DONE : ISSUE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Index counters, the valid pipeline, the operand registers and the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      rcv_q    <= '0;
      acc_q    <= '0;
      vld_q    <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      // NOTE: non-blocking assignments let later lines read the values from
      // the current cycle, whatever order the lines appear in.
      vld_q <= {vld_q[VD-2:0], issue};
      mul_a <= vld_q[0] ? a_rd_data : '0;
      mul_b <= vld_q[0] ? b_rd_data : '0;
      if (issue) begin
        a_addr_q <= a_addr_cur;
        b_addr_q <= b_addr_cur;
        k_q      <= k_q + IW'(1);
      end
      if (take) begin
        acc_q <= acc_nx;
        rcv_q <= rcv_q + CW'(1);
      end
      if (state == IDLE && start) begin
        i_q   <= '0;
        j_q   <= '0;
        k_q   <= '0;
        rcv_q <= '0;
        acc_q <= '0;
      end
      if (state == WRITE) begin
        acc_q <= '0;
        rcv_q <= '0;
        k_q   <= '0;
        if (j_q == IDX_LAST) begin
          j_q <= '0;
          i_q <= (i_q == IDX_LAST) ? '0 : i_q + IW'(1);
        end else begin
          j_q <= j_q + IW'(1);
        end
      end
    end
  end

endmodule

// File: doc/mat_operand_sequencer.md
Name: mat_operand_sequencer

Overview:
- Drives the operand side of the `mat` multiplier core: `mat` consumes A/B and returns C; this block produces A/B and consumes C.
- Walks a DIM x DIM matrix product C = A x B held in two operand RAMs.
- Streams element pairs into the multiplier and accumulates the returned products into dot products.
- Writes each finished result element to a result RAM port; sits between the operand/result memories and the `mat` core.

Parameters:
- DATA_W, 32, operand/product/result width (matches `mat` A/B/C).
- DIM, 4, matrix dimension (>=2).
- ADDR_W, 4, RAM address width; must satisfy 2**ADDR_W >= DIM*DIM.
- MUL_LAT, 1, cycles from mul_a/mul_b valid to mul_c valid; must equal the `mat` core latency.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin full matrix product; sampled only in IDLE.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse after the last result write.
- a_rd_addr  out  ADDR_W  A RAM read address, row-major.
- b_rd_addr  out  ADDR_W  B RAM read address, row-major.
- a_rd_data  in  DATA_W  A RAM data, 1-cycle synchronous read.
- b_rd_data  in  DATA_W  B RAM data, 1-cycle synchronous read.
- mul_a  out  DATA_W  to `mat` A.
- mul_b  out  DATA_W  to `mat` B.
- mul_c  in  DATA_W  from `mat` C.
- c_wr_en  out  1  result write strobe.
- c_wr_addr  out  ADDR_W  result address, i*DIM+j.
- c_wr_data  out  DATA_W  result value.

Behaviour:
- Reset: every output, counter, accumulator and valid pipeline clears to 0; FSM goes to IDLE. Reset mid-operation aborts with no further writes and no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 -> ISSUE with i=j=k=0 and acc=0.
  - start is ignored in every other state.
- ISSUE, one pair per cycle:
  - a_rd_addr = i*DIM+k, b_rd_addr = k*DIM+j.
  - Push a 1 into a valid shift register of depth 2+MUL_LAT.
  - After k=DIM-1 -> DRAIN.
- Datapath timing:
  - Address in cycle t, RAM data in t+1.
  - mul_a/mul_b registered from RAM data and visible in t+2.
  - mul_a/mul_b are 0 whenever their stage is not valid.
  - mul_c is sampled at the end of cycle t+2+MUL_LAT when the valid tap is high: acc <= acc + mul_c, and the received count increments.
- DRAIN: wait until the received count = DIM -> WRITE.
- WRITE, one cycle:
  - c_wr_en=1, c_wr_addr=i*DIM+j, c_wr_data=acc.
  - Then clear acc and the counts, and advance j (wraps to 0 with i++).
  - If (i,j) was (DIM-1,DIM-1) -> DONE, else -> ISSUE.
- DONE: done=1 for one cycle, then -> IDLE.
- Per-element period = DIM+MUL_LAT+3 cycles. With DIM=2, MUL_LAT=1 that is 6 cycles: start sampled at cycle 0, writes in cycles 6/12/18/24, done in cycle 25.
- busy is high from cycle 1 through the DONE cycle.
- Arithmetic: unsigned; the product is whatever `mat` returns (DATA_W bits); the accumulator wraps modulo 2**DATA_W.
- Address outputs hold their last value outside ISSUE; c_wr_addr/c_wr_data are 0 when c_wr_en=0.

Optional Feature:
- Macro MAT_SEQ_SAT_ACC_EN.
- Defined: saturating accumulate. If acc + mul_c overflows DATA_W bits, acc clamps to all-ones and stays clamped until the WRITE clears it.
- Undefined: plain modulo wrap.

Test Plan:
- DIM=2, MUL_LAT=1, A=[1,2;3,4], B=[5,6;7,8], start pulse -> writes (0,19)@cyc6, (1,22)@cyc12, (2,43)@cyc18, (3,50)@cyc24, done@cyc25, busy low @cyc26.
- DIM=4, A=identity, B=1..16 row-major -> 16 writes with c_wr_data == B[addr], addresses 0..15 in order, single done pulse.
- DIM=2, A all 0x0000FFFF, B all 0x00010001 (each product 0xFFFFFFFF) -> every element 0xFFFFFFFE without the macro, 0xFFFFFFFF with MAT_SEQ_SAT_ACC_EN.
- start re-pulsed at cycles 3 and 10 during a run -> write sequence and done timing identical to the first test; exactly one done.
- rst asserted at cycle 9 mid-run -> from next cycle busy=0, c_wr_en=0, mul_a=mul_b=0, no done. A fresh start then yields correct results from address 0.
- Back-to-back: start the cycle after done -> second run starts cleanly with acc=0 and produces identical results.
